// File: rtl/ps2_pkg.sv
// Shared types and constants for the PS/2 host-to-device transmitter.
// Holds the FSM state encoding, frame geometry and default timing values.
package ps2_pkg;

  typedef enum logic [2:0] {
    IDLE      = 3'd0,
    INHIBIT   = 3'd1,
    REQ       = 3'd2,
    SHIFT     = 3'd3,
    ACK       = 3'd4,
    WAIT_IDLE = 3'd5
  } ps2_state_e;

  localparam int DATA_BITS = 8;
  localparam int ACK_EDGE  = 11;

  localparam int DEF_INHIBIT_CYCLES = 2500;
  localparam int DEF_TIMEOUT_CYCLES = 375000;
  localparam int DEF_FILTER_LEN     = 4;

  // Odd parity: the nine bits {parity, data} always hold an odd number of ones.
  function automatic logic odd_parity(input logic [7:0] data);
    return ~^data;
  endfunction

endpackage

// File: rtl/ps2_line_filter.sv
// Two-flop synchroniser followed by a deglitcher for one PS/2 line.
// The filtered level only changes after FILTER_LEN equal synchronised samples.
module ps2_line_filter
  import ps2_pkg::*;
#(
  parameter int FILTER_LEN = DEF_FILTER_LEN
) (
  input  logic clk,
  input  logic reset,
  input  logic line_in,
  output logic level
);

  logic                  sync1_q;
  logic                  sync2_q;
  logic [FILTER_LEN-1:0] hist_q;
  logic [FILTER_LEN-1:0] hist_d;
  logic                  level_q;
  logic                  level_d;

  always_comb begin
    hist_d  = FILTER_LEN'({hist_q, sync2_q});
    level_d = level_q;
    if (&hist_d) begin
      level_d = 1'b1;
    end else if (~|hist_d) begin
      level_d = 1'b0;
    end else begin
      level_d = level_q;
    end
  end

  // Lines idle high, so every stage presets to 1 to avoid a false edge out of reset.
  always_ff @(posedge clk) begin
    if (reset) begin
      sync1_q <= 1'b1;
      sync2_q <= 1'b1;
      hist_q  <= {FILTER_LEN{1'b1}};
      level_q <= 1'b1;
    end else begin
      sync1_q <= line_in;
      sync2_q <= sync1_q;
      hist_q  <= hist_d;
      level_q <= level_d;
    end
  end

  assign level = level_q;

endmodule

// File: rtl/ps2_host_tx.sv
// PS/2 host-to-device byte transmitter: inhibits the clock, requests to send,
// shifts data/parity/stop on device clock falls and checks the device acknowledge.
module ps2_host_tx
  import ps2_pkg::*;
#(
  parameter int INHIBIT_CYCLES = DEF_INHIBIT_CYCLES,
  parameter int TIMEOUT_CYCLES = DEF_TIMEOUT_CYCLES,
  parameter int FILTER_LEN     = DEF_FILTER_LEN
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       tx_valid,
  input  logic [7:0] tx_data,
  output logic       tx_ready,
  input  logic       ps2_clk_in,
  input  logic       ps2_data_in,
  output logic       ps2_clk_oe,
  output logic       ps2_data_oe,
  output logic       busy,
  output logic       done,
  output logic       error
);

  localparam int IW = $clog2(INHIBIT_CYCLES + 1);
  localparam int WW = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [IW-1:0] INH_LAST  = IW'(INHIBIT_CYCLES - 1);
  localparam logic [WW-1:0] WDOG_LAST = WW'(TIMEOUT_CYCLES - 1);

  ps2_state_e    state_q, state_d;
  logic [IW-1:0] inh_cnt_q, inh_cnt_d, inh_nxt_s;
  logic [3:0]    bit_cnt_q, bit_cnt_d, bit_nxt_s;
  logic [WW-1:0] wdog_q, wdog_d;
  logic [7:0]    data_q, data_d;
  logic          parity_q, parity_d;
  logic          ack_q, ack_d;
  logic          clk_prev_q;
  logic          clk_oe_q, clk_oe_d;
  logic          data_oe_q, data_oe_d;
  logic          done_q, done_d;
  logic          error_q, error_d;
  logic          tx_ready_q, busy_q;
  logic          clk_level_s, data_level_s, clk_fall_s, wdog_hit_s;

  ps2_line_filter #(.FILTER_LEN(FILTER_LEN)) u_clk_filter (
    .clk     (clk),
    .reset   (reset),
    .line_in (ps2_clk_in),
    .level   (clk_level_s)
  );

  ps2_line_filter #(.FILTER_LEN(FILTER_LEN)) u_data_filter (
    .clk     (clk),
    .reset   (reset),
    .line_in (ps2_data_in),
    .level   (data_level_s)
  );

  assign clk_fall_s = clk_prev_q & ~clk_level_s;
  assign wdog_hit_s = (wdog_q == WDOG_LAST);
  assign inh_nxt_s  = inh_cnt_q + IW'(1);
  assign bit_nxt_s  = bit_cnt_q + 4'd1;

  always_comb begin
    state_d   = state_q;
    inh_cnt_d = inh_cnt_q;
    bit_cnt_d = bit_cnt_q;
    wdog_d    = wdog_q;
    data_d    = data_q;
    parity_d  = parity_q;
    ack_d     = ack_q;
    clk_oe_d  = 1'b0;
    data_oe_d = 1'b0;
    done_d    = 1'b0;
    error_d   = 1'b0;
    case (state_q)
      IDLE: begin
        if (tx_valid && tx_ready_q) begin
          state_d   = INHIBIT;
          data_d    = tx_data;
          parity_d  = odd_parity(tx_data);
          inh_cnt_d = {IW{1'b0}};
          clk_oe_d  = 1'b1;
          data_oe_d = (INH_LAST == {IW{1'b0}});
        end else begin
          state_d = IDLE;
        end
      end
      INHIBIT: begin
        if (inh_cnt_q == INH_LAST) begin
          state_d   = REQ;
          inh_cnt_d = {IW{1'b0}};
          wdog_d    = {WW{1'b0}};
          data_oe_d = 1'b1;
        end else begin
          // Data is pulled low during the final inhibit cycle.
          inh_cnt_d = inh_nxt_s;
          clk_oe_d  = 1'b1;
          data_oe_d = (inh_nxt_s == INH_LAST);
        end
      end
      REQ: begin
        data_oe_d = 1'b1;
        if (clk_fall_s) begin
          state_d   = SHIFT;
          bit_cnt_d = 4'd0;
          wdog_d    = {WW{1'b0}};
          data_oe_d = ~data_q[0];
        end else if (wdog_hit_s) begin
          state_d   = IDLE;
          wdog_d    = {WW{1'b0}};
          data_oe_d = 1'b0;
          error_d   = 1'b1;
        end else begin
          wdog_d = wdog_q + WW'(1);
        end
      end
      SHIFT: begin
        // bit_cnt_q indexes the bit on the wire: 0..7 data, 8 parity.
        data_oe_d = data_oe_q;
        if (clk_fall_s) begin
          wdog_d = {WW{1'b0}};
          if (bit_cnt_q == 4'(DATA_BITS)) begin
            state_d   = ACK;
            bit_cnt_d = 4'd0;
            data_oe_d = 1'b0;
          end else begin
            bit_cnt_d = bit_nxt_s;
            data_oe_d = bit_nxt_s[3] ? ~parity_q : ~data_q[bit_nxt_s[2:0]];
          end
        end else if (wdog_hit_s) begin
          state_d   = IDLE;
          bit_cnt_d = 4'd0;
          wdog_d    = {WW{1'b0}};
          data_oe_d = 1'b0;
          error_d   = 1'b1;
        end else begin
          wdog_d = wdog_q + WW'(1);
        end
      end
      ACK: begin
        if (clk_fall_s) begin
          state_d = WAIT_IDLE;
          wdog_d  = {WW{1'b0}};
          ack_d   = ~data_level_s;
        end else if (wdog_hit_s) begin
          state_d = IDLE;
          wdog_d  = {WW{1'b0}};
          error_d = 1'b1;
        end else begin
          wdog_d = wdog_q + WW'(1);
        end
      end
      WAIT_IDLE: begin
        if (clk_level_s && data_level_s) begin
          state_d = IDLE;
          done_d  = ack_q;
          error_d = ~ack_q;
        end else begin
          state_d = WAIT_IDLE;
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // Handshake and status flags are registered from the next state so they
  // line up with the done/error pulse cycle.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q    <= IDLE;
      inh_cnt_q  <= {IW{1'b0}};
      bit_cnt_q  <= 4'd0;
      wdog_q     <= {WW{1'b0}};
      data_q     <= 8'd0;
      parity_q   <= 1'b0;
      ack_q      <= 1'b0;
      clk_prev_q <= 1'b1;
      clk_oe_q   <= 1'b0;
      data_oe_q  <= 1'b0;
      done_q     <= 1'b0;
      error_q    <= 1'b0;
      tx_ready_q <= 1'b1;
      busy_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      inh_cnt_q  <= inh_cnt_d;
      bit_cnt_q  <= bit_cnt_d;
      wdog_q     <= wdog_d;
      data_q     <= data_d;
      parity_q   <= parity_d;
      ack_q      <= ack_d;
      clk_prev_q <= clk_level_s;
      clk_oe_q   <= clk_oe_d;
      data_oe_q  <= data_oe_d;
      done_q     <= done_d;
      error_q    <= error_d;
      tx_ready_q <= (state_d == IDLE);
      busy_q     <= (state_d != IDLE);
    end
  end

  assign tx_ready    = tx_ready_q;
  assign busy        = busy_q;
  assign ps2_clk_oe  = clk_oe_q;
  assign ps2_data_oe = data_oe_q;
  assign done        = done_q;
  assign error       = error_q;

endmodule

// File: tb/tb_ps2_host_tx.sv
// Self-checking bench for ps2_host_tx: an open-collector keyboard model clocks
// the frame, captures what it samples and compares against an expected frame.
module tb_ps2_host_tx;
  import ps2_pkg::*;

  localparam int INH = 2500;
  localparam int TMO = 3000;

  logic       clk;
  logic       reset;
  logic       tx_valid;
  logic [7:0] tx_data;
  logic       tx_ready;
  logic       ps2_clk_in;
  logic       ps2_data_in;
  logic       ps2_clk_oe;
  logic       ps2_data_oe;
  logic       busy;
  logic       done;
  logic       error;
  logic       dev_clk;
  logic       dev_data;

  int cyc         = 0;
  int done_cnt    = 0;
  int err_cnt     = 0;
  int overlap_bad = 0;
  int passed      = 0;
  int fails       = 0;
  int total       = 0;
  int t_req_r     = 0;

  // Wired-AND bus: either side may pull a line low.
  assign ps2_clk_in  = dev_clk & ~ps2_clk_oe;
  assign ps2_data_in = dev_data & ~ps2_data_oe;

  ps2_host_tx #(
    .INHIBIT_CYCLES (INH),
    .TIMEOUT_CYCLES (TMO),
    .FILTER_LEN     (4)
  ) dut (
    .clk         (clk),
    .reset       (reset),
    .tx_valid    (tx_valid),
    .tx_data     (tx_data),
    .tx_ready    (tx_ready),
    .ps2_clk_in  (ps2_clk_in),
    .ps2_data_in (ps2_data_in),
    .ps2_clk_oe  (ps2_clk_oe),
    .ps2_data_oe (ps2_data_oe),
    .busy        (busy),
    .done        (done),
    .error       (error)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  always @(posedge clk) cyc <= cyc + 1;

  always @(negedge clk) begin
    if (done === 1'b1) done_cnt++;
    if (error === 1'b1) err_cnt++;
    if ((done === 1'b1) && (error === 1'b1)) overlap_bad++;
    if (((done === 1'b1) || (error === 1'b1)) && (busy !== 1'b0)) overlap_bad++;
  end

  task automatic chk(input string tag, input int obs, input int exp);
    total++;
    assert (obs === exp) passed++;
    else begin
      fails++;
      $error("FAIL %s: observed %0d (0x%0h) expected %0d (0x%0h)", tag, obs, obs, exp, exp);
    end
  endtask

  // Expected line samples: start 0, data LSB first, odd parity, stop 1.
  function automatic logic [10:0] frame_model(input logic [7:0] d);
    logic [10:0] f;
    int ones;
    ones = 0;
    for (int i = 0; i < 8; i++) ones += int'(d[i]);
    f[0] = 1'b0;
    for (int i = 0; i < 8; i++) f[i+1] = d[i];
    f[9]  = ((ones % 2) == 0);
    f[10] = 1'b1;
    return f;
  endfunction

  task automatic start_tx(input logic [7:0] d);
    int guard;
    guard = 0;
    while (tx_ready !== 1'b1 && guard < 2000) begin
      @(negedge clk);
      guard++;
    end
    chk("ready_before_send", int'(tx_ready), 1);
    tx_data  = d;
    tx_valid = 1'b1;
    @(negedge clk);
    tx_valid = 1'b0;
    chk("busy_after_accept", int'(busy), 1);
  endtask

  task automatic measure_inhibit();
    int n_hi;
    int n_both;
    int guard;
    n_hi   = 0;
    n_both = 0;
    guard  = 0;
    while (ps2_clk_oe === 1'b1 && guard < INH + 100) begin
      n_hi++;
      if (ps2_data_oe === 1'b1) n_both++;
      @(negedge clk);
      guard++;
    end
    t_req_r = cyc;
    chk("inhibit_len", n_hi, INH);
    chk("inhibit_data_last_cycle", n_both, 1);
    chk("start_bit_driven", int'(ps2_data_oe), 1);
  endtask

  task automatic clock_frame(input int edges, input bit do_ack, input bit inject,
                             output logic [10:0] bits);
    int hp;
    hp   = int'($urandom_range(25, 12));
    bits = 11'd0;
    repeat (hp) @(negedge clk);
    for (int e = 1; e <= edges; e++) begin
      bits = {ps2_data_in, bits[10:1]};
      if (e == ACK_EDGE && do_ack) begin
        dev_data = 1'b0;
        repeat (10) @(negedge clk);
      end
      dev_clk = 1'b0;
      repeat (hp) @(negedge clk);
      if (inject && e == 3) begin
        chk("ready_low_while_busy", int'(tx_ready), 0);
        tx_data  = 8'h55;
        tx_valid = 1'b1;
        @(negedge clk);
        tx_valid = 1'b0;
      end
      dev_clk = 1'b1;
      repeat (hp) @(negedge clk);
    end
    dev_data = 1'b1;
  endtask

  task automatic full_send(input logic [7:0] d, input bit do_ack, input bit inject,
                           input string tag, output logic [10:0] bits);
    int d0;
    int e0;
    int guard;
    d0 = done_cnt;
    e0 = err_cnt;
    start_tx(d);
    measure_inhibit();
    clock_frame(ACK_EDGE, do_ack, inject, bits);
    chk({tag, "_frame"}, int'(bits), int'(frame_model(d)));
    guard = 0;
    while (done_cnt == d0 && err_cnt == e0 && guard < 300) begin
      @(negedge clk);
      guard++;
    end
    repeat (2) @(negedge clk);
    chk({tag, "_done_count"}, done_cnt - d0, do_ack ? 1 : 0);
    chk({tag, "_error_count"}, err_cnt - e0, do_ack ? 0 : 1);
    chk({tag, "_ready_after"}, int'(tx_ready), 1);
  endtask

  initial begin
    logic [10:0] bits;
    logic [7:0]  rb;
    int          d0;
    int          e0;
    int          guard;
    int          hi_cnt;

    reset    = 1'b1;
    tx_valid = 1'b0;
    tx_data  = 8'h00;
    dev_clk  = 1'b1;
    dev_data = 1'b1;
    repeat (5) @(negedge clk);
    reset = 1'b0;
    @(negedge clk);
    chk("reset_tx_ready", int'(tx_ready), 1);
    chk("reset_busy", int'(busy), 0);
    chk("reset_clk_oe", int'(ps2_clk_oe), 0);
    chk("reset_data_oe", int'(ps2_data_oe), 0);
    chk("reset_done", int'(done), 0);
    chk("reset_error", int'(error), 0);

    full_send(8'hED, 1'b1, 1'b0, "ed", bits);
    chk("ed_wire_samples", int'(bits), 'h7DA);
    full_send(8'hFF, 1'b1, 1'b0, "ff", bits);
    chk("ff_parity", int'(bits[9]), 1);
    full_send(8'h00, 1'b1, 1'b0, "zero", bits);
    chk("zero_parity", int'(bits[9]), 1);
    full_send(8'h01, 1'b1, 1'b0, "one", bits);
    chk("one_parity", int'(bits[9]), 0);

    full_send(8'hF4, 1'b1, 1'b1, "f4_inject", bits);
    hi_cnt = 0;
    repeat (50) begin
      @(negedge clk);
      if (ps2_clk_oe === 1'b1) hi_cnt++;
    end
    chk("no_queued_send", hi_cnt, 0);

    for (int i = 0; i < 4; i++) begin
      rb = 8'($urandom);
      full_send(rb, 1'b1, 1'b0, "rand", bits);
    end

    rb = 8'($urandom);
    full_send(rb, 1'b0, 1'b0, "noack", bits);

    d0 = done_cnt;
    e0 = err_cnt;
    start_tx(8'($urandom));
    measure_inhibit();
    guard = 0;
    while (error !== 1'b1 && guard < TMO + 200) begin
      @(negedge clk);
      guard++;
    end
    chk("timeout_latency", cyc - t_req_r, TMO);
    chk("timeout_clk_oe", int'(ps2_clk_oe), 0);
    chk("timeout_data_oe", int'(ps2_data_oe), 0);
    repeat (2) @(negedge clk);
    chk("timeout_error_count", err_cnt - e0, 1);
    chk("timeout_done_count", done_cnt - d0, 0);

    d0 = done_cnt;
    e0 = err_cnt;
    start_tx(8'hED);
    measure_inhibit();
    clock_frame(5, 1'b0, 1'b0, bits);
    chk("pre_reset_bit4_driven", int'(ps2_data_oe), 1);
    reset = 1'b1;
    @(negedge clk);
    chk("midreset_clk_oe", int'(ps2_clk_oe), 0);
    chk("midreset_data_oe", int'(ps2_data_oe), 0);
    reset = 1'b0;
    repeat (30) @(negedge clk);
    chk("midreset_done_count", done_cnt - d0, 0);
    chk("midreset_error_count", err_cnt - e0, 0);
    chk("midreset_ready", int'(tx_ready), 1);
    full_send(8'hED, 1'b1, 1'b0, "ed_after_reset", bits);
    chk("ed_after_reset_wire_samples", int'(bits), 'h7DA);

    chk("done_error_busy_exclusive", overlap_bad, 0);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule

// File: doc/ps2_host_tx.md
PS2_HOST_TX -- requirements
Module: ps2_host_tx

Interface
REQ-001 SHALL have parameter INHIBIT_CYCLES, default 2500, clock-low inhibit time (100 us at 25 MHz).
REQ-002 SHALL have parameter TIMEOUT_CYCLES, default 375000, watchdog limit between device clock falling edges (15 ms at 25 MHz).
REQ-003 SHALL have parameter FILTER_LEN, default 4, consecutive equal samples required to accept a line level.
REQ-004 clk  input  1  system clock (25 MHz); the only clock.
REQ-005 reset  input  1  synchronous, active-high reset.
REQ-006 tx_valid  input  1  request to send tx_data.
REQ-007 tx_data  input  8  command byte to keyboard, e.g. 0xED (set LEDs) or 0xFF (reset).
REQ-008 tx_ready  output  1  high when the block accepts a new byte.
REQ-009 ps2_clk_in  input  1  raw PS/2 clock pin level.
REQ-010 ps2_data_in  input  1  raw PS/2 data pin level.
REQ-011 ps2_clk_oe  output  1  1 = drive PS/2 clock low; 0 = release (pull-up).
REQ-012 ps2_data_oe  output  1  1 = drive PS/2 data low; 0 = release.
REQ-013 busy  output  1  high from byte acceptance until the block returns to IDLE.
REQ-014 done  output  1  one-cycle pulse: byte sent and device acknowledged.
REQ-015 error  output  1  one-cycle pulse: no acknowledge or watchdog timeout.

Function
REQ-016 SHALL pass both inputs through a 2-FF synchroniser, then a FILTER_LEN deglitcher; falling edge = filtered clock 1->0.
REQ-017 Handshake: transfer occurs on a cycle where tx_valid && tx_ready; tx_data SHALL be latched and odd parity computed (parity = ~^tx_data).
REQ-018 tx_ready SHALL be high only in IDLE; tx_valid outside IDLE SHALL be ignored, with no queuing.
REQ-019 States: IDLE, INHIBIT, REQ, SHIFT, ACK, WAIT_IDLE.
REQ-020 IDLE->INHIBIT on acceptance: ps2_clk_oe=1 for INHIBIT_CYCLES cycles; ps2_data_oe SHALL rise to 1 in the last INHIBIT cycle.
REQ-021 INHIBIT->REQ: ps2_clk_oe=0, ps2_data_oe=1 (start bit); wait for the first falling edge.
REQ-022 SHIFT: after falling edge n (n=1..8), drive data bit n-1 (LSB first); after edge 9, drive parity; after edge 10, release data (stop). Drive a data value of 1 as oe=0 and 0 as oe=1. Apply each value the cycle after the edge is detected.
REQ-023 ACK: at falling edge 11, sample filtered data; 0 = ack, 1 = no ack.
REQ-024 WAIT_IDLE: once both filtered lines are high, return to IDLE and pulse done (ack) or error (no ack) in that cycle.
REQ-025 The watchdog SHALL clear on entry to REQ and on every falling edge. If it reaches TIMEOUT_CYCLES in REQ, SHIFT, or ACK, the block SHALL release both lines, pulse error, and enter IDLE.
REQ-026 done and error SHALL never assert in the same cycle; busy SHALL be low in the cycle done or error pulses.
REQ-027 Bit counter SHALL be 4 bits and the watchdog counter $clog2(TIMEOUT_CYCLES+1) bits; neither wraps, and both clear on state entry.
REQ-028 Outside INHIBIT, REQ, and SHIFT, ps2_clk_oe SHALL be 0; ps2_data_oe SHALL be 0 in IDLE, ACK, and WAIT_IDLE.

Reset
REQ-029 On reset: state=IDLE, ps2_clk_oe=0, ps2_data_oe=0, tx_ready=1 in the first cycle after reset deasserts, busy=0, done=0, error=0, all counters 0, filters preset to 1 (idle high).
REQ-030 Reset mid-transfer SHALL release both lines in the next clk edge and produce no done or error pulse.

Structure
REQ-031 Package ps2_pkg SHALL hold the state enum, the frame constants (DATA_BITS=8, ACK_EDGE=11), and the default timing constants.
REQ-032 Sub-module ps2_line_filter (sync + deglitch, parameter FILTER_LEN), instantiated once for clock and once for data.

Verification
REQ-033 Send 0xED with a device model that acks: ps2_clk_oe high exactly 2500 cycles; model samples 0,1,0,1,1,0,1,1,1,1,1 (start, data LSB first, parity=1, stop); done pulses once.
REQ-034 Send 0xFF: parity bit=1 (eight ones); data=0x00: parity=1; data=0x01: parity=0, all checked at the device model.
REQ-035 Device does not pull data low at edge 11: error pulses, done stays 0, and tx_ready returns high.
REQ-036 Device never clocks after the request: error at exactly TIMEOUT_CYCLES after REQ entry; both oe outputs 0.
REQ-037 tx_valid pulsed with 0x55 while busy sending 0xF4: only 0xF4 appears on the wire.
REQ-038 Reset asserted after edge 5: both oe outputs 0 the next cycle; no done or error; a subsequent send of 0xED completes normally.
